// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Holds the arbiter FSM state encoding and the default byte width / idle-limit constants.
// No logic; imported by the arbiter top and its picker.
package uart_pkg;

  localparam int UART_DWIDTH = 8;
  localparam int UART_TMO    = 255;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first asserted request scanning upward from last_owner+1 (mod NREQ).
// Latency: purely combinational.
// Backpressure: none; grant is all-zero when no request is asserted.
// Ports: req (per-requester request), last_owner (index of previous owner), grant (one-hot).
module uart_rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_owner,
  output logic [NREQ-1:0] grant
);

  int          idx;
  logic [IW-1:0] idx_w;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    idx_w = '0;
    // k = 1 first, so the previous owner is considered last.
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_owner) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IW'(idx);
      if (!found && req[idx_w]) begin
        grant[idx_w] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter feeding a UART transmitter through a one-entry output register.
// Latency: 2 cycles from a request in IDLE to m_axis_tvalid; one IDLE bubble between packets.
// Backpressure: only the owner sees tready, high when the output register is empty or draining.
// Ports: uart_clk/uart_rst (sync, active-high); s_axis_* NREQ requesters (tdata packed per requester);
//        m_axis_* to the UART transmitter; arb_grant one-hot owner; arb_timeout force-release pulse.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int DWIDTH = UART_DWIDTH,
  parameter int NREQ   = 2,
  parameter int TMO    = UART_TMO
) (
  input  logic                   uart_clk,
  input  logic                   uart_rst,
  input  logic [NREQ*DWIDTH-1:0] s_axis_tdata,
  input  logic [NREQ-1:0]        s_axis_tvalid,
  input  logic [NREQ-1:0]        s_axis_tlast,
  output logic [NREQ-1:0]        s_axis_tready,
  output logic [DWIDTH-1:0]      m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic [NREQ-1:0]        arb_grant,
  output logic                   arb_timeout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
  // Idle count value at which the next idle cycle triggers the force-release.
  localparam logic [CW-1:0] TMO_LAST = CW'((TMO > 0) ? TMO - 1 : 0);

  arb_state_t      state_q, state_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   last_owner_q, last_owner_nxt;
  logic [IW-1:0]   g_idx;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic            tmo_nxt;

  logic [DWIDTH-1:0] sel_dat;
  logic              vld_g;
  logic              last_g;
  logic              slot_free;
  logic              accept;

  uart_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req        (s_axis_tvalid),
    .last_owner (last_owner_q),
    .grant      (pick_grant)
  );

  // Owner view of the inputs; arb_grant is zero in IDLE so everything masks off there.
  always_comb begin
    sel_dat = '0;
    g_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        sel_dat = s_axis_tdata[i*DWIDTH +: DWIDTH];
        g_idx   = IW'(i);
      end
    end
  end

  assign vld_g         = |(s_axis_tvalid & arb_grant);
  assign last_g        = |(s_axis_tlast & arb_grant);
  assign slot_free     = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state_q == ST_PKT && slot_free) ? arb_grant : '0;
  assign accept        = vld_g && slot_free && (state_q == ST_PKT);

  always_comb begin
    state_nxt      = state_q;
    grant_nxt      = arb_grant;
    last_owner_nxt = last_owner_q;
    cnt_nxt        = cnt_q;
    tmo_nxt        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (|s_axis_tvalid) begin
          state_nxt = ST_PKT;
          grant_nxt = pick_grant;
        end
      end
      ST_PKT: begin
        if (accept && last_g) begin
          state_nxt      = ST_IDLE;
          grant_nxt      = '0;
          last_owner_nxt = g_idx;
          cnt_nxt        = '0;
        end else if (vld_g) begin
          // Owner is presenting data (accepted or stalled downstream): not idle.
          cnt_nxt = '0;
        end else if (TMO > 0 && cnt_q == TMO_LAST) begin
          state_nxt      = ST_IDLE;
          grant_nxt      = '0;
          last_owner_nxt = g_idx;
          cnt_nxt        = '0;
          tmo_nxt        = 1'b1;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge uart_clk) begin
    if (uart_rst) begin
      state_q       <= ST_IDLE;
      arb_grant     <= '0;
      last_owner_q  <= IW'(NREQ - 1);
      cnt_q         <= '0;
      arb_timeout   <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      arb_grant    <= grant_nxt;
      last_owner_q <= last_owner_nxt;
      cnt_q        <= cnt_nxt;
      arb_timeout  <= tmo_nxt;
      // A buffered beat survives a timeout and drains with its own tlast.
      if (accept) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= sel_dat;
        m_axis_tlast  <= last_g;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, meaning data byte width.
REQ-002 SHALL have parameter NREQ, default 2, meaning number of requesters (2..8).
REQ-003 SHALL have parameter TMO, default 255, meaning idle-cycle limit inside a packet; 0 disables the limit.
REQ-004 SHALL have port uart_clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port uart_rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port s_axis_tdata  in  NREQ*DWIDTH  requester data; requester i occupies bits [i*DWIDTH +: DWIDTH].
REQ-007 SHALL have port s_axis_tvalid  in  NREQ  per-requester valid.
REQ-008 SHALL have port s_axis_tlast  in  NREQ  per-requester end of packet.
REQ-009 SHALL have port s_axis_tready  out  NREQ  per-requester ready.
REQ-010 SHALL have port m_axis_tdata  out  DWIDTH  data to the UART transmitter.
REQ-011 SHALL have port m_axis_tvalid  out  1  output valid.
REQ-012 SHALL have port m_axis_tlast  out  1  output end of packet.
REQ-013 SHALL have port m_axis_tready  in  1  ready from the UART transmitter.
REQ-014 SHALL have port arb_grant  out  NREQ  one-hot current owner; all-zero when idle.
REQ-015 SHALL have port arb_timeout  out  1  one-cycle pulse when a packet is force-released.

Function
REQ-016 SHALL implement states IDLE and PKT, held in a registered FSM.
REQ-017 SHALL, in IDLE with any s_axis_tvalid high, grant the first valid requester scanning upward from (last_owner+1) mod NREQ, latch arb_grant, and enter PKT on the next edge.
REQ-018 SHALL keep all s_axis_tready low in IDLE and for non-granted requesters in PKT.
REQ-019 SHALL drive s_axis_tready[g] = !m_axis_tvalid || m_axis_tready in PKT, where g is the granted requester.
REQ-020 SHALL transfer accepted beats (valid&&ready) into a one-entry output register (data, last) and set m_axis_tvalid on the next edge; combinational input-to-output paths are forbidden.
REQ-021 SHALL clear m_axis_tvalid after an output handshake unless a new beat is loaded in the same cycle; a simultaneous drain and load keeps m_axis_tvalid high with the new beat.
REQ-022 SHALL hold m_axis_tdata/m_axis_tlast stable while m_axis_tvalid && !m_axis_tready.
REQ-023 SHALL, on acceptance of a beat with tlast high, return to IDLE on the next edge, clear arb_grant, and record g as last_owner.
REQ-024 SHALL yield a latency of 2 cycles from s_axis_tvalid rising in IDLE to m_axis_tvalid high, given m_axis_tready high, and a 1-cycle IDLE bubble between consecutive packets.
REQ-025 SHALL never interleave beats of different requesters; a grant lasts until tlast or timeout.
REQ-026 SHALL count consecutive PKT cycles with s_axis_tvalid[g] low; when TMO>0 and the count reaches TMO, SHALL go to IDLE, pulse arb_timeout for one cycle, and set last_owner = g; the count resets on every accepted beat.
REQ-027 SHALL let a beat already in the output register drain normally after a timeout, with its tlast unchanged.
REQ-028 SHALL ignore tlast on non-granted requesters.

Reset
REQ-029 SHALL, while uart_rst is high at an edge, set the state to IDLE, arb_grant=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, arb_timeout=0, the timeout count to 0, and last_owner=NREQ-1 so that requester 0 wins first.
REQ-030 SHALL discard an in-flight packet and any buffered beat on reset mid-operation; no beat is emitted after reset.

Structure
REQ-031 SHALL place the FSM state encoding (IDLE, PKT) and the default DWIDTH/TMO constants in a shared uart_pkg package.
REQ-032 SHALL instantiate one sub-module, uart_rr_pick, a combinational round-robin picker with inputs req and last_owner and a one-hot grant output.
REQ-033 SHALL connect m_axis_* directly to the uart_tx s_axis_* ports without glue logic.

Verification
REQ-034 Bench SHALL cover: reset, then req0 sends 3 bytes 0x11, 0x22, 0x33 (last on 0x33) with m_axis_tready=1 -> m_axis_tvalid first high 2 cycles after tvalid, bytes in order, tlast only on 0x33, then arb_grant=0.
REQ-035 Bench SHALL cover: req0 and req1 both valid from reset with 2-byte packets 0xA0, 0xA1 and 0xB0, 0xB1 -> output A0, A1, B0, B1; the next simultaneous request grants req0 again.
REQ-036 Bench SHALL cover: m_axis_tready held low for 5 cycles mid-packet -> m_axis_tdata stable, s_axis_tready low, and no byte lost or duplicated.
REQ-037 Bench SHALL cover: TMO=4, req1 sends 0x55 without tlast then drops valid -> arb_timeout pulses once 4 cycles later, 0x55 is emitted, and req0 is granted next.
REQ-038 Bench SHALL cover: uart_rst asserted mid-packet with a beat buffered -> all outputs zero on the next edge, and req0 is granted first after release.
REQ-039 Bench SHALL cover: a req1 tlast pulse while req0 owns the grant -> req0's packet is unaffected.
